pht_update_queue: RTL and testbench

- Write-side companion to the gshare predictor's PHT read path.
- Accepts resolved branch results from commit and computes the updated 2-bit saturating counter and PHT index.
- Buffers each update in a FIFO of PhtQueueEntry records, then drains one entry per cycle into the PHT's write port when the arbiter grants it.
- Decouples commit from PHT BRAM port contention with the fetch-stage read.

---
 rtl/pht_update_queue_pkg.sv | 41 ++++
 rtl/pht_update_queue_fifo.sv | 84 ++++++++
 rtl/pht_update_queue.sv | 103 ++++++++++
 tb/tb_pht_update_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pht_update_queue_pkg.sv
// pht_update_queue_pkg
//   Shared fetch-unit types for the gshare PHT write path: queue record,
//   pointer/index/counter widths, the gshare index hash and the 2-bit
//   saturating counter update.
package pht_update_queue_pkg;

  localparam int PC_WIDTH                        = 32;
  localparam int INSN_ADDR_BIT_WIDTH             = 2;
  localparam int PHT_ENTRY_NUM_BIT_WIDTH         = 11;
  localparam int BRANCH_GLOBAL_HISTORY_BIT_WIDTH = 10;
  localparam int PHT_QUEUE_SIZE                  = 32;
  localparam int PHT_ENTRY_WIDTH                 = 2;

  typedef logic [PC_WIDTH-1:0]                        PC_Path;
  typedef logic [BRANCH_GLOBAL_HISTORY_BIT_WIDTH-1:0] BranchGlobalHistoryPath;
  typedef logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0]         PHT_IndexPath;
  typedef logic [PHT_ENTRY_WIDTH-1:0]                 PHT_EntryPath;
  typedef logic [$clog2(PHT_QUEUE_SIZE)-1:0]          PhtQueuePointerPath;

  localparam PHT_EntryPath PHT_ENTRY_MAX = 2'd3;

  typedef struct packed {
    PHT_IndexPath phtWA;
    PHT_EntryPath phtWV;
  } PhtQueueEntry;

  // gshare hash: word-aligned PC bits XOR zero-extended global history.
  function automatic PHT_IndexPath ToPHT_Index_GShare(PC_Path addr,
                                                      BranchGlobalHistoryPath hist);
    return addr[INSN_ADDR_BIT_WIDTH +: PHT_ENTRY_NUM_BIT_WIDTH] ^ PHT_IndexPath'(hist);
  endfunction

  // 2-bit saturating counter; clamps at 0 and PHT_ENTRY_MAX, never wraps.
  function automatic PHT_EntryPath UpdatePHT_Counter(PHT_EntryPath prev, logic taken);
    if (taken) begin
      return (prev == PHT_ENTRY_MAX) ? prev : prev + PHT_EntryPath'(1);
    end
    return (prev == PHT_EntryPath'(0)) ? prev : prev - PHT_EntryPath'(1);
  endfunction

endpackage

// File: rtl/pht_update_queue_fifo.sv
// pht_update_queue_fifo
//   Generic registered circular FIFO. Head entry is presented
//   combinationally; pushes become visible at the head one cycle later.
// Ports:
//   clk, rst         clock, async active-high reset
//   push, push_data  write request and data
//   pop              read request (ignored when empty)
//   head_data        current head entry
//   full, empty      flags derived from registered count
//   count            number of stored entries
module pht_update_queue_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[head_q];

  // When full, a concurrent pop frees the slot the push lands in
  // (tail == head); the head is read this cycle before being overwritten.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (push_ok) begin
      mem_d[tail_q] = push_data;
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop_ok) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is read while count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pht_update_queue.sv
// pht_update_queue
//   Write-side companion to the gshare PHT read path. Commits resolved
//   conditional branches, computes the new 2-bit counter and PHT index,
//   queues them, and drains one per granted cycle into the PHT write port.
// Ports:
//   clk, rst              clock, async active-high reset
//   brValid, brIsCondBr   branch result strobe / conditional qualifier
//   brAddr, brExecTaken   branch PC and resolved direction
//   brGlobalHistory       history used at prediction time
//   brPhtPrevValue        counter read at prediction time
//   phtWriteGrant         PHT write port available this cycle
//   phtWE, phtWA, phtWV   PHT write enable / index / value
//   queueFull, queueEmpty queue occupancy flags
//   dropCount             saturating count of updates lost to overflow
module pht_update_queue
  import pht_update_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH     = PHT_QUEUE_SIZE,
  parameter int PHT_INDEX_WIDTH = PHT_ENTRY_NUM_BIT_WIDTH,
  parameter int HISTORY_WIDTH   = BRANCH_GLOBAL_HISTORY_BIT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       brValid,
  input  logic                       brIsCondBr,
  input  logic [PC_WIDTH-1:0]        brAddr,
  input  logic                       brExecTaken,
  input  logic [HISTORY_WIDTH-1:0]   brGlobalHistory,
  input  logic [1:0]                 brPhtPrevValue,
  input  logic                       phtWriteGrant,
  output logic                       phtWE,
  output logic [PHT_INDEX_WIDTH-1:0] phtWA,
  output logic [1:0]                 phtWV,
  output logic                       queueFull,
  output logic                       queueEmpty,
  output logic [15:0]                dropCount
);

  localparam int ENTRY_W = PHT_INDEX_WIDTH + PHT_ENTRY_WIDTH;
  localparam int HI_LSB  = INSN_ADDR_BIT_WIDTH + PHT_INDEX_WIDTH;

  logic                       push_req;
  logic                       pop_req;
  logic [PHT_INDEX_WIDTH-1:0] push_idx;
  PHT_EntryPath               push_ctr;
  logic [ENTRY_W-1:0]         push_entry;
  logic [ENTRY_W-1:0]         head_entry;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(QUEUE_DEPTH):0] unused_fifo_count;
  logic                       unused_addr_bits;
  logic [15:0]                drop_count_q, drop_count_d;

  assign push_req = brValid & brIsCondBr;
  assign pop_req  = phtWriteGrant & ~fifo_empty;

  assign push_idx   = brAddr[INSN_ADDR_BIT_WIDTH +: PHT_INDEX_WIDTH]
                    ^ PHT_INDEX_WIDTH'(brGlobalHistory);
  assign push_ctr   = UpdatePHT_Counter(brPhtPrevValue, brExecTaken);
  assign push_entry = {push_idx, push_ctr};

  // PC byte-offset bits and bits above the hashed window do not feed the index.
  assign unused_addr_bits = ^{brAddr[INSN_ADDR_BIT_WIDTH-1:0], brAddr[PC_WIDTH-1:HI_LSB]};

  pht_update_queue_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (pop_req),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  assign phtWE      = pop_req;
  assign phtWA      = head_entry[ENTRY_W-1 -: PHT_INDEX_WIDTH];
  assign phtWV      = head_entry[PHT_ENTRY_WIDTH-1:0];
  assign queueFull  = fifo_full;
  assign queueEmpty = fifo_empty;
  assign dropCount  = drop_count_q;

  // A push is lost only when full with no concurrent pop; commit never stalls.
  always_comb begin
    drop_count_d = drop_count_q;
    if (push_req && fifo_full && !pop_req && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_pht_update_queue.sv
module tb_pht_update_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        brValid;
  logic        brIsCondBr;
  logic [31:0] brAddr;
  logic        brExecTaken;
  logic [9:0]  brGlobalHistory;
  logic [1:0]  brPhtPrevValue;
  logic        phtWriteGrant;
  logic        phtWE;
  logic [10:0] phtWA;
  logic [1:0]  phtWV;
  logic        queueFull;
  logic        queueEmpty;
  logic [15:0] dropCount;

  int n_chk  = 0;
  int n_fail = 0;

  pht_update_queue dut (
    .clk             (clk),
    .rst             (rst),
    .brValid         (brValid),
    .brIsCondBr      (brIsCondBr),
    .brAddr          (brAddr),
    .brExecTaken     (brExecTaken),
    .brGlobalHistory (brGlobalHistory),
    .brPhtPrevValue  (brPhtPrevValue),
    .phtWriteGrant   (phtWriteGrant),
    .phtWE           (phtWE),
    .phtWA           (phtWA),
    .phtWV           (phtWV),
    .queueFull       (queueFull),
    .queueEmpty      (queueEmpty),
    .dropCount       (dropCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_br(input logic v, input logic cond, input logic [31:0] addr,
                          input logic [9:0] hist, input logic [1:0] prev, input logic tk);
    brValid         = v;
    brIsCondBr      = cond;
    brAddr          = addr;
    brGlobalHistory = hist;
    brPhtPrevValue  = prev;
    brExecTaken     = tk;
  endtask

  // Hand-written counter update tables, indexed by previous value.
  function automatic logic [1:0] exp_ctr(input int prev, input logic tk);
    logic [1:0] up_tab [4];
    logic [1:0] dn_tab [4];
    up_tab = '{2'd1, 2'd2, 2'd3, 2'd3};
    dn_tab = '{2'd0, 2'd0, 2'd1, 2'd2};
    return tk ? up_tab[prev] : dn_tab[prev];
  endfunction

  // Overflow-test entry i: index i+16 (history 0), prev i%4, taken when i%3==0.
  function automatic logic ov_taken(input int i);
    return (i % 3) == 0;
  endfunction

  initial begin
    rst = 1'b1;
    phtWriteGrant = 1'b0;
    drive_br(1'b0, 1'b0, 32'h0, 10'h0, 2'd0, 1'b0);
    #2;
    chk("reset_we",    32'(phtWE), 32'd0);
    chk("reset_empty", 32'(queueEmpty), 32'd1);
    chk("reset_full",  32'(queueFull), 32'd0);
    chk("reset_drop",  32'(dropCount), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single update: index = 0x1008[12:2] (0x402) ^ 0x005 = 0x407, counter 1->2.
    phtWriteGrant = 1'b1;
    drive_br(1'b1, 1'b1, 32'h0000_1008, 10'h005, 2'd1, 1'b1);
    #1;
    chk("no_bypass_we", 32'(phtWE), 32'd0);
    tick();
    drive_br(1'b0, 1'b0, 32'h0, 10'h0, 2'd0, 1'b0);
    #1;
    chk("single_we", 32'(phtWE), 32'd1);
    chk("single_wa", 32'(phtWA), 32'h407);
    chk("single_wv", 32'(phtWV), 32'd2);
    tick();
    chk("single_empty", 32'(queueEmpty), 32'd1);
    chk("single_we_off", 32'(phtWE), 32'd0);

    // Saturation corner cases, queued then drained.
    phtWriteGrant = 1'b0;
    drive_br(1'b1, 1'b1, 32'h0000_2000, 10'h000, 2'd3, 1'b1); tick();
    drive_br(1'b1, 1'b1, 32'h0000_0004, 10'h3FF, 2'd0, 1'b0); tick();
    drive_br(1'b1, 1'b1, 32'h0000_0010, 10'h001, 2'd2, 1'b0); tick();
    drive_br(1'b0, 1'b0, 32'h0, 10'h0, 2'd0, 1'b0);
    phtWriteGrant = 1'b1;
    #1;
    chk("sat_hi_wa", 32'(phtWA), 32'h000);
    chk("sat_hi_wv", 32'(phtWV), 32'd3);
    tick();
    chk("sat_lo_wa", 32'(phtWA), 32'h3FE);
    chk("sat_lo_wv", 32'(phtWV), 32'd0);
    tick();
    chk("dec_wa", 32'(phtWA), 32'h005);
    chk("dec_wv", 32'(phtWV), 32'd1);
    tick();
    chk("sat_empty", 32'(queueEmpty), 32'd1);

    // Filtering: unconditional branch, then brValid low.
    drive_br(1'b1, 1'b0, 32'h0000_0040, 10'h0, 2'd1, 1'b1); tick();
    drive_br(1'b0, 1'b0, 32'h0, 10'h0, 2'd0, 1'b0);
    #1;
    chk("filt_uncond_we", 32'(phtWE), 32'd0);
    chk("filt_uncond_empty", 32'(queueEmpty), 32'd1);
    drive_br(1'b0, 1'b1, 32'h0000_0044, 10'h0, 2'd1, 1'b1); tick();
    drive_br(1'b0, 1'b0, 32'h0, 10'h0, 2'd0, 1'b0);
    #1;
    chk("filt_novalid_we", 32'(phtWE), 32'd0);
    chk("filt_novalid_empty", 32'(queueEmpty), 32'd1);

    // Push and pop together with one entry queued.
    phtWriteGrant = 1'b0;
    drive_br(1'b1, 1'b1, 32'h0000_0080, 10'h0, 2'd1, 1'b0); tick();   // idx 0x20, wv 0
    phtWriteGrant = 1'b1;
    drive_br(1'b1, 1'b1, 32'h0000_0084, 10'h0, 2'd2, 1'b1);           // idx 0x21, wv 3
    #1;
    chk("c1_first_wa", 32'(phtWA), 32'h020);
    chk("c1_first_wv", 32'(phtWV), 32'd0);
    tick();
    drive_br(1'b0, 1'b0, 32'h0, 10'h0, 2'd0, 1'b0);
    #1;
    chk("c1_second_we", 32'(phtWE), 32'd1);
    chk("c1_second_wa", 32'(phtWA), 32'h021);
    chk("c1_second_wv", 32'(phtWV), 32'd3);
    tick();
    chk("c1_empty", 32'(queueEmpty), 32'd1);

    // Overflow: 33 pushes with no grant; the 33rd is dropped.
    phtWriteGrant = 1'b0;
    for (int i = 0; i < 33; i++) begin
      drive_br(1'b1, 1'b1, 32'((i + 16) << 2), 10'h0, 2'(i % 4), ov_taken(i));
      #1;
      if (i == 32) chk("ov_full_after_32", 32'(queueFull), 32'd1);
      tick();
    end
    drive_br(1'b0, 1'b0, 32'h0, 10'h0, 2'd0, 1'b0);
    #1;
    chk("ov_drop", 32'(dropCount), 32'd1);
    chk("ov_still_full", 32'(queueFull), 32'd1);

    // Full with simultaneous push and pop: push accepted, nothing dropped.
    phtWriteGrant = 1'b1;
    drive_br(1'b1, 1'b1, 32'(100 << 2), 10'h0, 2'd1, 1'b0);           // idx 100, wv 0
    #1;
    chk("fp_we", 32'(phtWE), 32'd1);
    chk("fp_wa0", 32'(phtWA), 32'd16);
    chk("fp_wv0", 32'(phtWV), 32'(exp_ctr(0, ov_taken(0))));
    tick();
    drive_br(1'b0, 1'b0, 32'h0, 10'h0, 2'd0, 1'b0);
    #1;
    chk("fp_full", 32'(queueFull), 32'd1);
    chk("fp_drop", 32'(dropCount), 32'd1);
    for (int k = 1; k < 32; k++) begin
      chk($sformatf("drain_we_%0d", k), 32'(phtWE), 32'd1);
      chk($sformatf("drain_wa_%0d", k), 32'(phtWA), 32'(k + 16));
      chk($sformatf("drain_wv_%0d", k), 32'(phtWV), 32'(exp_ctr(k % 4, ov_taken(k))));
      tick();
    end
    chk("drain_last_wa", 32'(phtWA), 32'd100);
    chk("drain_last_wv", 32'(phtWV), 32'd0);
    tick();
    chk("drain_empty", 32'(queueEmpty), 32'd1);
    chk("drain_we_off", 32'(phtWE), 32'd0);
    chk("drain_drop", 32'(dropCount), 32'd1);

    // Asynchronous reset in the middle of a drain.
    phtWriteGrant = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_br(1'b1, 1'b1, 32'((i + 200) << 2), 10'h0, 2'd1, 1'b1);
      tick();
    end
    drive_br(1'b0, 1'b0, 32'h0, 10'h0, 2'd0, 1'b0);
    phtWriteGrant = 1'b1;
    tick();
    tick();
    #2;
    chk("mid_we_before", 32'(phtWE), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_we", 32'(phtWE), 32'd0);
    chk("arst_empty", 32'(queueEmpty), 32'd1);
    chk("arst_drop", 32'(dropCount), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("post_rst_we_%0d", i), 32'(phtWE), 32'd0);
      tick();
    end
    chk("post_rst_empty", 32'(queueEmpty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
